// File: rtl/eight_queen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eight_queen_pkg
// Purpose  : Shared board size, checker state encoding and error codes for
//            the eight-queen solution checker.
// Revision : 1.0 - initial release
// ============================================================================
package eight_queen_pkg;

    // Default board size (rows, columns, out_bus width)
    localparam int c_BOARD_N = 8;

    // Checker state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE       = 3'd0;
    localparam state_t c_ST_WAIT_READY = 3'd1;
    localparam state_t c_ST_START      = 3'd2;
    localparam state_t c_ST_CAPTURE    = 3'd3;
    localparam state_t c_ST_CHECK      = 3'd4;
    localparam state_t c_ST_REPORT     = 3'd5;

    // Verdict codes reported on error_code
    localparam logic [2:0] c_ERR_OK      = 3'd0;
    localparam logic [2:0] c_ERR_ONEHOT  = 3'd1;
    localparam logic [2:0] c_ERR_COLUMN  = 3'd2;
    localparam logic [2:0] c_ERR_DIAG    = 3'd3;
    localparam logic [2:0] c_ERR_TIMEOUT = 3'd4;

endpackage
`default_nettype wire

// File: rtl/onehot_row_encoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_row_encoder
// Purpose  : Combinational one-hot row mask to column index converter with a
//            flag telling whether exactly one bit of the mask is set.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_row_encoder
    import eight_queen_pkg::*;
#(
    parameter int N = c_BOARD_N
) (
    input  logic [N-1:0]         mask,
    output logic [$clog2(N)-1:0] index,
    output logic                 is_onehot
);

    localparam int c_W = $clog2(N);

    // OR-reduce the positions of set bits; exact when the mask is one-hot
    always_comb begin
        index     = '0;
        is_onehot = (mask != '0) && ((mask & (mask - N'(1))) == '0);
        for (int k = 0; k < N; k++) begin
            if (mask[k]) begin
                index = index | c_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eight_queen_solution_checker.sv
`default_nettype none
// ============================================================================
// Module   : eight_queen_solution_checker
// Purpose  : Starts an eight-queen solver, captures the streamed board (one
//            one-hot row per cycle), and checks every row pair for column and
//            diagonal attacks, reporting pass/fail with an error code.
// Options  : CHECKER_TIMEOUT_EN - adds a watchdog on the wait for ready/done
//            (error code 4 after TIMEOUT_CYCLES cycles).
// Revision : 1.0 - initial release
// ============================================================================
module eight_queen_solution_checker
    import eight_queen_pkg::*;
#(
    parameter int N              = c_BOARD_N,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 user_reset,
    input  logic                 go,
    output logic                 start,
    input  logic                 ready,
    input  logic                 done,
    input  logic [N-1:0]         out_bus,
    output logic                 busy,
    output logic                 result_valid,
    output logic                 pass,
    output logic [2:0]           error_code,
    output logic [$clog2(N)-1:0] err_row
);

    localparam int c_W = $clog2(N);

    state_t          r_state;
    logic [c_W-1:0]  r_col [N];
    logic [c_W-1:0]  r_row;
    logic [c_W-1:0]  r_pi;
    logic [c_W-1:0]  r_pj;

    logic [c_W-1:0]  w_enc_idx;
    logic            w_enc_onehot;
    logic            w_capture;
    logic            w_err_latched;
    logic [c_W:0]    w_ci;
    logic [c_W:0]    w_cj;
    logic [c_W:0]    w_col_dist;
    logic [c_W:0]    w_row_dist;
    logic            w_timeout;

    onehot_row_encoder #(
        .N (N)
    ) u_encoder (
        .mask      (out_bus),
        .index     (w_enc_idx),
        .is_onehot (w_enc_onehot)
    );

    // Row 0 arrives in the cycle done is first seen, so capture starts in START
    assign w_capture     = ((r_state == c_ST_START) && done) || (r_state == c_ST_CAPTURE);
    assign w_err_latched = (error_code != c_ERR_OK);

    // Distances are unsigned on one extra bit so no wrap can fake a diagonal
    assign w_ci       = {1'b0, r_col[r_pi]};
    assign w_cj       = {1'b0, r_col[r_pj]};
    assign w_col_dist = (w_ci >= w_cj) ? (w_ci - w_cj) : (w_cj - w_ci);
    assign w_row_dist = {1'b0, r_pj} - {1'b0, r_pi};

`ifdef CHECKER_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0] r_tmo_cnt;

    // Watchdog counts cycles spent waiting on the solver; cleared per accepted go
    always_ff @(posedge clk or posedge user_reset) begin
        if (user_reset) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == c_ST_IDLE) && go) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == c_ST_WAIT_READY) || (r_state == c_ST_START)) begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end

    assign w_timeout = ((r_state == c_ST_WAIT_READY) || (r_state == c_ST_START)) &&
                       (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Control FSM, row capture and pairwise attack check
    always_ff @(posedge clk or posedge user_reset) begin
        if (user_reset) begin
            r_state      <= c_ST_IDLE;
            start        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            pass         <= 1'b0;
            error_code   <= c_ERR_OK;
            err_row      <= '0;
            r_row        <= '0;
            r_pi         <= '0;
            r_pj         <= '0;
            for (int k = 0; k < N; k++) begin
                r_col[k] <= '0;
            end
        end else begin
            result_valid <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (go) begin
                        r_state    <= c_ST_WAIT_READY;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        error_code <= c_ERR_OK;
                        err_row    <= '0;
                        r_row      <= '0;
                    end
                end

                c_ST_WAIT_READY: begin
                    if (w_timeout) begin
                        error_code <= c_ERR_TIMEOUT;
                        r_state    <= c_ST_REPORT;
                    end else if (ready) begin
                        start   <= 1'b1;
                        r_state <= c_ST_START;
                    end
                end

                c_ST_START: begin
                    if (done) begin
                        start   <= 1'b0;
                        r_state <= c_ST_CAPTURE;
                    end else if (w_timeout) begin
                        start      <= 1'b0;
                        error_code <= c_ERR_TIMEOUT;
                        r_state    <= c_ST_REPORT;
                    end
                end

                c_ST_CAPTURE: begin
                    if (r_row == c_W'(N - 1)) begin
                        r_state <= (w_err_latched || !w_enc_onehot) ? c_ST_REPORT : c_ST_CHECK;
                        r_pi    <= '0;
                        r_pj    <= c_W'(1);
                    end
                end

                c_ST_CHECK: begin
                    if (r_col[r_pi] == r_col[r_pj]) begin
                        error_code <= c_ERR_COLUMN;
                        err_row    <= r_pi;
                        r_state    <= c_ST_REPORT;
                    end else if (w_col_dist == w_row_dist) begin
                        error_code <= c_ERR_DIAG;
                        err_row    <= r_pi;
                        r_state    <= c_ST_REPORT;
                    end else if (r_pj == c_W'(N - 1)) begin
                        if (r_pi == c_W'(N - 2)) begin
                            r_state <= c_ST_REPORT;
                        end else begin
                            r_pi <= r_pi + c_W'(1);
                            r_pj <= r_pi + c_W'(2);
                        end
                    end else begin
                        r_pj <= r_pj + c_W'(1);
                    end
                end

                c_ST_REPORT: begin
                    result_valid <= 1'b1;
                    pass         <= (error_code == c_ERR_OK);
                    busy         <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            // Every streamed row is stored; only the first malformed row is reported
            if (w_capture) begin
                r_col[r_row] <= w_enc_idx;
                r_row        <= r_row + c_W'(1);
                if (!w_enc_onehot && !w_err_latched) begin
                    error_code <= c_ERR_ONEHOT;
                    err_row    <= r_row;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eight_queen_solution_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_eight_queen_solution_checker
// Purpose  : Directed, table-driven bench for the eight-queen solution
//            checker; the bench plays the solver side of the handshake.
// Options  : CHECKER_TIMEOUT_EN - exercises the watchdog (TIMEOUT_CYCLES=50).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eight_queen_solution_checker;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       user_reset;
    logic       go;
    logic       start;
    logic       ready;
    logic       done;
    logic [7:0] out_bus;
    logic       busy;
    logic       result_valid;
    logic       pass;
    logic [2:0] error_code;
    logic [2:0] err_row;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    eight_queen_solution_checker #(
        .N              (N),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk          (clk),
        .user_reset   (user_reset),
        .go           (go),
        .start        (start),
        .ready        (ready),
        .done         (done),
        .out_bus      (out_bus),
        .busy         (busy),
        .result_valid (result_valid),
        .pass         (pass),
        .error_code   (error_code),
        .err_row      (err_row)
    );

    typedef struct {
        string       name;
        logic [63:0] board;      // row r in bits [8r+7:8r]
        int          ready_dly;
        int          done_dly;
        bit          go_mid;
        int          exp_pass;
        int          exp_code;
        int          exp_row;
        int          exp_lat;    // cycles from last captured row to result_valid
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_rows(input logic [63:0] board, input bit go_mid, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            done    = (r == 0);
            out_bus = board[8*r +: 8];
            go      = go_mid && (r == 4);
            @(negedge clk);
        end
        done    = 1'b0;
        out_bus = 8'h00;
        go      = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int cyc;
        ready = (v.ready_dly == 0);
        go    = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk({v.name, " busy_after_go"}, int'(busy), 1);
        n = 0;
        while (!start && n < 60) begin
            @(negedge clk);
            n++;
            if (n >= v.ready_dly) ready = 1'b1;
        end
        chk({v.name, " start_latency"}, n, v.ready_dly + 1);
        repeat (v.done_dly) @(negedge clk);
        chk({v.name, " start_held"}, int'(start), 1);
        send_rows(v.board, v.go_mid, N);
        chk({v.name, " start_dropped"}, int'(start), 0);
        cyc = 0;
        while (!result_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({v.name, " result_latency"}, cyc, v.exp_lat);
        chk({v.name, " pass"}, int'(pass), v.exp_pass);
        chk({v.name, " error_code"}, int'(error_code), v.exp_code);
        chk({v.name, " err_row"}, int'(err_row), v.exp_row);
        chk({v.name, " busy_at_result"}, int'(busy), 0);
        @(negedge clk);
        chk({v.name, " result_valid_pulse"}, int'(result_valid), 0);
        chk({v.name, " pass_held"}, int'(pass), v.exp_pass);
        chk({v.name, " code_held"}, int'(error_code), v.exp_code);
        if (v.go_mid) begin
            repeat (3) @(negedge clk);
            chk({v.name, " go_ignored_busy"}, int'(busy), 0);
            chk({v.name, " go_ignored_start"}, int'(start), 0);
        end
    endtask

    initial begin
        int cyc;
        user_reset = 1'b1;
        go         = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;
        out_bus    = 8'h00;

        // Directed boards; latencies are 28 check cycles + 1 report cycle for clean
        // boards, 1 for a malformed row, and (pair index + 2) for a failing pair.
        vecs[0] = '{"valid_a",     64'h08_02_40_04_20_80_10_01, 0, 0, 1'b0, 1, 0, 0, 29};
        vecs[1] = '{"valid_b",     64'h10_02_08_40_04_80_20_01, 3, 5, 1'b0, 1, 0, 0, 29};
        vecs[2] = '{"row3_0x21",   64'h08_02_40_04_21_80_10_01, 0, 2, 1'b0, 0, 1, 3, 1};
        vecs[3] = '{"row6_zero",   64'h08_00_40_04_20_80_10_01, 1, 0, 1'b0, 0, 1, 6, 1};
        vecs[4] = '{"first_bad",   64'h08_02_FF_04_20_00_10_01, 0, 1, 1'b0, 0, 1, 2, 1};
        vecs[5] = '{"col_r0_r5",   64'h08_02_01_04_20_80_10_01, 0, 0, 1'b0, 0, 2, 0, 6};
        vecs[6] = '{"diag_r0_r1",  64'h80_40_20_10_08_04_02_01, 2, 0, 1'b0, 0, 3, 0, 2};
        vecs[7] = '{"diag_r0_r7",  64'h80_20_08_02_40_10_04_01, 0, 4, 1'b0, 0, 3, 0, 8};
        vecs[8] = '{"diag_r1_r7",  64'h40_04_40_02_80_10_01_08, 0, 0, 1'b0, 0, 3, 1, 14};
        vecs[9] = '{"go_in_busy",  64'h08_02_40_04_20_80_10_01, 0, 1, 1'b1, 1, 0, 0, 29};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset start", int'(start), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset result_valid", int'(result_valid), 0);
        chk("reset pass", int'(pass), 0);
        chk("reset error_code", int'(error_code), 0);
        chk("reset err_row", int'(err_row), 0);
        user_reset = 1'b0;
        @(negedge clk);
        chk("idle busy", int'(busy), 0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Reset mid-capture after a malformed row has latched an error
        ready = 1'b1;
        go    = 1'b1;
        @(negedge clk);
        go  = 1'b0;
        cyc = 0;
        while (!start && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort start_seen", int'(start), 1);
        send_rows(64'h08_02_40_04_20_80_00_01, 1'b0, 4);
        chk("abort code_before_reset", int'(error_code), 1);
        user_reset = 1'b1;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort start", int'(start), 0);
        chk("abort error_code", int'(error_code), 0);
        chk("abort err_row", int'(err_row), 0);
        chk("abort pass", int'(pass), 0);
        chk("abort result_valid", int'(result_valid), 0);
        @(negedge clk);
        user_reset = 1'b0;
        cyc = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_valid) cyc++;
        end
        chk("abort no_result", cyc, 0);
        run_vec(vecs[0]);

`ifdef CHECKER_TIMEOUT_EN
        // Watchdog: done never arrives; twice to show the counter restarts per go
        for (int k = 0; k < 2; k++) begin
            ready = 1'b1;
            go    = 1'b1;
            @(negedge clk);
            go  = 1'b0;
            cyc = 0;
            while (!result_valid && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            chk("timeout latency", cyc, 51);
            chk("timeout error_code", int'(error_code), 4);
            chk("timeout pass", int'(pass), 0);
            chk("timeout start", int'(start), 0);
            chk("timeout busy", int'(busy), 0);
            @(negedge clk);
        end
`else
        // Without the watchdog the checker waits on done indefinitely
        ready = 1'b1;
        go    = 1'b1;
        @(negedge clk);
        go  = 1'b0;
        cyc = 0;
        repeat (120) begin
            @(negedge clk);
            if (result_valid) cyc++;
        end
        chk("no_timeout result", cyc, 0);
        chk("no_timeout start", int'(start), 1);
        chk("no_timeout busy", int'(busy), 1);
        send_rows(64'h08_02_40_04_20_80_10_01, 1'b0, N);
        cyc = 0;
        while (!result_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("no_timeout late_latency", cyc, 29);
        chk("no_timeout late_pass", int'(pass), 1);
        chk("no_timeout late_code", int'(error_code), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eight_queen_solution_checker.md
Name: eight_queen_solution_checker

Overview:
- Consumer end of the eight_queen solver interface: drives `start`, watches `ready`/`done`, and captures the board streamed on `out_bus`.
- Converts each one-hot row byte to a column index, then checks every row pair for column and diagonal attacks.
- Reports pass/fail plus an error code.
- Sits beside the solver in self-checking top-levels and on-board bring-up.

Parameters:
- N, 8, board size; also the `out_bus` width and the number of rows captured.
- TIMEOUT_CYCLES, 100000, watchdog limit while waiting for `done` (used only with CHECKER_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- user_reset  in  1  asynchronous, active-high reset.
- go  in  1  single-cycle request to run one solve-and-check.
- start  out  1  start request to the solver.
- ready  in  1  solver idle / able to accept start.
- done  in  1  solver finished; rows follow on `out_bus`.
- out_bus  in  N  one row per cycle, one-hot column mask, row 0 first.
- busy  out  1  high from accepted `go` until `result_valid`.
- result_valid  out  1  one-cycle pulse when the verdict is ready.
- pass  out  1  verdict, held until the next accepted `go`.
- error_code  out  3  0 ok, 1 row not one-hot, 2 column conflict, 3 diagonal conflict, 4 timeout; held with `pass`.
- err_row  out  $clog2(N)  first offending row index (the lower row of a failing pair).

Behaviour:
- Reset (async, any state): state=IDLE; start, busy, result_valid, pass=0; error_code=0; err_row=0; column registers=0.
- IDLE:
  - `go`=1 → WAIT_READY, busy=1.
  - `go` while busy is ignored.
- WAIT_READY:
  - When `ready`=1 → START.
- START:
  - `start`=1, held until `done` is seen, then go to CAPTURE.
  - The cycle `done` is first sampled high is row 0.
- CAPTURE: N cycles, row counter r=0..N-1. Each cycle:
  - The encoder converts `out_bus` to col[r].
  - If `out_bus` is not exactly one-hot and no error is latched yet: latch error_code=1, err_row=r.
  - Capture always completes all N rows.
  - `done` may drop during capture; it is not rechecked.
  - Exit: error already latched → REPORT; otherwise → CHECK.
- CHECK: one pair (i,j), i<j, per cycle.
  - Order: i=0..N-2, with j=i+1..N-1 (28 cycles for N=8).
  - col[i]==col[j] → error 2.
  - |col[i]-col[j]| == j-i → error 3. Compute the distance unsigned on $clog2(N)+1 bits.
  - First failure latches and goes to REPORT. Otherwise go to REPORT after the last pair.
- REPORT (1 cycle):
  - result_valid=1.
  - pass=(error_code==0).
  - busy=0.
  - Then return to IDLE.
- Latency, go to result (ready already high, clean board): 2 + solver time + N + N(N-1)/2 + 1 cycles.
- Reset mid-run aborts immediately. The solver is not reset by this block.

Optional Feature:
- Macro: CHECKER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_READY and START.
  - Reaching TIMEOUT_CYCLES → error_code=4, `start` drops, then REPORT.
  - The counter is cleared on each accepted `go`.
- Undefined:
  - No counter is synthesized; the block waits indefinitely.
  - Code 4 is never produced.

Decomposition:
- Shared package `eight_queen_pkg`:
  - Board-size constant.
  - State enum {IDLE, WAIT_READY, START, CAPTURE, CHECK, REPORT}.
  - Error-code constants.
- One sub-module, `onehot_row_encoder` (purely combinational, used from the sequential checker):
  - Input: N-bit mask.
  - Outputs: index, plus is_onehot flag.

Test Plan:
- Valid board 0x01,0x10,0x80,0x20,0x04,0x40,0x02,0x08 (cols 0,4,7,5,2,6,1,3) → pass=1, error_code=0, result_valid 28+1 cycles after capture ends.
- Row 3 = 0x21 → error_code=1, err_row=3, no CHECK phase entered.
- Rows 0 and 5 both 0x01 (otherwise distinct) → error_code=2, err_row=0.
- Board 0x01,0x02,… (diagonal in rows 0 and 1) → error_code=3, err_row=0 on the first pair.
- Reset asserted mid-CAPTURE, then `go` again with a valid board → all outputs cleared; second run passes.
- CHECKER_TIMEOUT_EN with TIMEOUT_CYCLES=50 and `done` held low → error_code=4 after 50 cycles, `start` deasserted, pass=0.
